// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core (FCH/DEC/EXE/MEM/WRB): stage enables, stage valids, fetch flush, halt.
// Latency: enables, fch_flush and halted are combinational from state+inputs; stage valids update on the next clk edge.
// Backpressure: mem_busy freezes every stage; a DEC hazard stalls FCH/DEC and bubbles EXE; optional counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fch_valid,
  input  logic             dec_stall,
  input  logic             dec_load_use,
  input  logic             dec_csr_use,
  input  logic             exe_redirect,
  input  logic             mem_busy,
  input  logic             trap_req,
  input  logic             halt_req,
  output logic             fch_enb,
  output logic             dec_enb,
  output logic             exe_enb,
  output logic             mem_enb,
  output logic             dec_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wrb_valid,
  output logic             fch_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_csr,
  output logic [CNT_W-1:0] cnt_mem
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEMWAIT,
    ST_FLUSH,
    ST_HALT
  } state_t;

  // FLUSH counts down to zero, so it is loaded with one less than the dwell time.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_flush_cnt;
  logic [3:0] w_flush_cnt_nxt;

  logic r_dec_vld;
  logic r_exe_vld;
  logic r_mem_vld;
  logic r_wrb_vld;
  logic w_dec_vld_nxt;
  logic w_exe_vld_nxt;
  logic w_mem_vld_nxt;
  logic w_wrb_vld_nxt;

  logic w_fch_en;
  logic w_dec_en;
  logic w_exe_en;
  logic w_mem_en;
  logic w_flush;
  logic w_halted;

  // Conditions only count when the stage that raises them holds a real instruction.
  logic w_mhold;
  logic w_trap;
  logic w_redir;
  logic w_dhold;

  assign w_mhold = r_mem_vld & mem_busy;
  assign w_trap  = r_wrb_vld & trap_req;
  assign w_redir = r_exe_vld & exe_redirect;
  assign w_dhold = r_dec_vld & dec_stall;

  // Next-state, next-valid and enable decode; MEMWAIT shares RUN's priority chain since
  // mem_valid is held there, so mhold simply re-evaluates to mem_busy.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_dec_vld_nxt   = r_dec_vld;
    w_exe_vld_nxt   = r_exe_vld;
    w_mem_vld_nxt   = r_mem_vld;
    w_wrb_vld_nxt   = r_wrb_vld;
    w_fch_en        = 1'b0;
    w_dec_en        = 1'b0;
    w_exe_en        = 1'b0;
    w_mem_en        = 1'b0;
    w_flush         = 1'b0;
    w_halted        = 1'b0;

    case (r_state)
      ST_RUN, ST_MEMWAIT: begin
        if (w_trap) begin
          // Trap kills everything in flight, including a MEM access still waiting.
          w_dec_vld_nxt   = 1'b0;
          w_exe_vld_nxt   = 1'b0;
          w_mem_vld_nxt   = 1'b0;
          w_wrb_vld_nxt   = 1'b0;
          w_flush         = 1'b1;
          w_flush_cnt_nxt = FLUSH_LOAD;
          w_state_nxt     = ST_FLUSH;
        end else if (w_mhold) begin
          // Freeze all stages; WRB retires its instruction and takes a bubble.
          w_wrb_vld_nxt = 1'b0;
          w_state_nxt   = ST_MEMWAIT;
        end else begin
          w_state_nxt   = ST_RUN;
          w_wrb_vld_nxt = r_mem_vld;
          w_mem_vld_nxt = r_exe_vld;
          if (w_redir) begin
            // DEC and FCH hold wrong-path work, so a DEC hazard is irrelevant here.
            w_fch_en      = ~halt_req;
            w_dec_en      = 1'b1;
            w_exe_en      = 1'b1;
            w_mem_en      = 1'b1;
            w_flush       = 1'b1;
            w_dec_vld_nxt = 1'b0;
            w_exe_vld_nxt = 1'b0;
          end else if (w_dhold) begin
            // DEC keeps its instruction; a bubble goes into EXE.
            w_exe_en      = 1'b1;
            w_mem_en      = 1'b1;
            w_exe_vld_nxt = 1'b0;
          end else begin
            // A pending halt stops fetch and lets the rest of the pipe drain.
            w_fch_en      = ~halt_req;
            w_dec_en      = 1'b1;
            w_exe_en      = 1'b1;
            w_mem_en      = 1'b1;
            w_dec_vld_nxt = fch_valid & ~halt_req;
            w_exe_vld_nxt = r_dec_vld;
          end
          if (halt_req && !(w_dec_vld_nxt | w_exe_vld_nxt | w_mem_vld_nxt | w_wrb_vld_nxt)) begin
            w_state_nxt = ST_HALT;
          end
        end
      end

      ST_FLUSH: begin
        // Redirect, DEC stall and mem_busy are ignored while the trap target is fetched.
        w_dec_vld_nxt = 1'b0;
        w_exe_vld_nxt = 1'b0;
        w_mem_vld_nxt = 1'b0;
        w_wrb_vld_nxt = 1'b0;
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = halt_req ? ST_HALT : ST_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end

      ST_HALT: begin
        // halted drops in the same cycle halt_req is released; fetch restarts next cycle.
        w_halted      = halt_req;
        w_dec_vld_nxt = 1'b0;
        w_exe_vld_nxt = 1'b0;
        w_mem_vld_nxt = 1'b0;
        w_wrb_vld_nxt = 1'b0;
        if (!halt_req) begin
          w_state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // State, flush countdown and stage-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 4'd0;
      r_dec_vld   <= 1'b0;
      r_exe_vld   <= 1'b0;
      r_mem_vld   <= 1'b0;
      r_wrb_vld   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_dec_vld   <= w_dec_vld_nxt;
      r_exe_vld   <= w_exe_vld_nxt;
      r_mem_vld   <= w_mem_vld_nxt;
      r_wrb_vld   <= w_wrb_vld_nxt;
    end
  end

  assign fch_enb   = w_fch_en & ~reset;
  assign dec_enb   = w_dec_en & ~reset;
  assign exe_enb   = w_exe_en & ~reset;
  assign mem_enb   = w_mem_en & ~reset;
  assign fch_flush = w_flush  & ~reset;
  assign halted    = w_halted & ~reset;
  assign dec_valid = r_dec_vld;
  assign exe_valid = r_exe_vld;
  assign mem_valid = r_mem_vld;
  assign wrb_valid = r_wrb_vld;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cnt_load;
  logic [CNT_W-1:0] r_cnt_csr;
  logic [CNT_W-1:0] r_cnt_mem;
  logic             w_stall_cyc;
  logic             w_load_inc;
  logic             w_csr_inc;

  // A DEC stall cycle counts only when it actually holds the pipe; dhold needs dec_valid, so bubbles never count.
  assign w_stall_cyc = w_dhold & ~w_redir & ~w_mhold & ~w_trap;
  assign w_load_inc  = w_stall_cyc & dec_load_use;
  assign w_csr_inc   = w_stall_cyc & dec_csr_use;

  // Saturating stall-cause counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_load <= '0;
      r_cnt_csr  <= '0;
      r_cnt_mem  <= '0;
    end else begin
      if (w_load_inc && (r_cnt_load != '1)) r_cnt_load <= r_cnt_load + CNT_W'(1);
      if (w_csr_inc  && (r_cnt_csr  != '1)) r_cnt_csr  <= r_cnt_csr  + CNT_W'(1);
      if (w_mhold    && (r_cnt_mem  != '1)) r_cnt_mem  <= r_cnt_mem  + CNT_W'(1);
    end
  end

  assign cnt_load = r_cnt_load;
  assign cnt_csr  = r_cnt_csr;
  assign cnt_mem  = r_cnt_mem;
`else
  // Cause qualifiers only feed the counters.
  logic w_unused_perf;
  assign w_unused_perf = dec_load_use ^ dec_csr_use;

  assign cnt_load = '0;
  assign cnt_csr  = '0;
  assign cnt_mem  = '0;
`endif

endmodule
